// File: rtl/acc_sequencer.sv
// acc_sequencer: command FIFO plus control-strobe sequencer for the
// 8-bit adder/accumulator datapath; it owns every datapath control pin.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready registered)
//   cmd_op, cmd_data      opcode and operand
//   dp_data               byte to the datapath input buffer
//   dp_nla, dp_nlb        load A / load B from bus (active-low)
//   dp_ea, dp_eu          A / ALU drives bus
//   dp_sub, dp_bus_sel    ALU subtract, output mux select (1 = bus)
//   dp_cf, dp_zf          datapath carry / zero flags
//   done, err             completion / illegal-opcode pulses
//   cf_q, zf_q            flags captured on the last ADD/SUB
//   busy                  FSM active or commands queued
//
// Build option: ACC_SEQ_OUT_CMD_EN enables the OUT command (opcode 100).
// Without it opcode 100 is illegal and dp_bus_sel is always 0.
module acc_sequencer #(
    parameter int DATA_W = 8,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] dp_data,
    output logic              dp_nla,
    output logic              dp_nlb,
    output logic              dp_ea,
    output logic              dp_eu,
    output logic              dp_sub,
    output logic              dp_bus_sel,
    input  logic              dp_cf,
    input  logic              dp_zf,
    output logic              done,
    output logic              err,
    output logic              cf_q,
    output logic              zf_q,
    output logic              busy
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_CLR = 3'b101;

    localparam logic [PW:0] CNT_ONE  = 1;
    localparam logic [PW:0] CNT_FULL = QDEPTH[PW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LDB,
        S_ALU,
        S_LDA,
        S_OUT,
        S_FLAG,
        S_DONE
    } state_t;

    function automatic logic is_bad(input logic [2:0] op);
`ifdef ACC_SEQ_OUT_CMD_EN
        return op[2] & op[1];
`else
        return (op[2] & op[1]) | (op == OP_OUT);
`endif
    endfunction

    // ---------------- command FIFO ----------------
    logic [2:0]        q_op   [QDEPTH];
    logic [DATA_W-1:0] q_data [QDEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [PW:0]       count_nxt;
    logic              ready_q;
    logic              push;
    logic              pop;

    state_t state;
    state_t state_nxt;

    assign push = cmd_valid & ready_q;
    assign pop  = (state == S_IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_op[wr_ptr]   <= cmd_op;
            q_data[wr_ptr] <= cmd_data;
        end
    end

    // Pointers are PW bits wide and QDEPTH is a power of two,
    // so natural overflow gives the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt != CNT_FULL);
        end
    end

    assign cmd_ready = ready_q;

    // ---------------- command latch ----------------
    logic [2:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic              bad_q;
    logic              pop_bad;

    assign pop_bad = is_bad(q_op[rd_ptr]);

    // CLR and illegal commands present a zero byte so that nothing
    // but zero can ever reach the input buffer for them.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NOP;
            data_q <= '0;
            bad_q  <= 1'b0;
        end else if (pop) begin
            op_q  <= q_op[rd_ptr];
            bad_q <= pop_bad;
            if (pop_bad || q_op[rd_ptr] == OP_CLR) begin
                data_q <= '0;
            end else begin
                data_q <= q_data[rd_ptr];
            end
        end
    end

    // ---------------- sequencer FSM ----------------
    logic op_ld;
    logic op_alu;

    assign op_ld  = (op_q == OP_LDA) || (op_q == OP_CLR);
    assign op_alu = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pop) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                unique case (1'b1)
                    bad_q:            state_nxt = S_DONE;
                    (op_q == OP_NOP): state_nxt = S_DONE;
                    op_ld:            state_nxt = S_LDA;
                    op_alu:           state_nxt = S_LDB;
`ifdef ACC_SEQ_OUT_CMD_EN
                    (op_q == OP_OUT): state_nxt = S_OUT;
`endif
                    default:          state_nxt = S_DONE;
                endcase
            end
            S_LDB:   state_nxt = S_ALU;
            S_ALU:   state_nxt = S_FLAG;
            S_FLAG:  state_nxt = S_DONE;
            S_LDA:   state_nxt = S_DONE;
            S_OUT:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decode straight from the state register.
    // dp_data is only non-zero in states where nothing drives the
    // bus, so it can never collide with dp_ea/dp_eu.
    always_comb begin
        dp_data    = '0;
        dp_nla     = 1'b1;
        dp_nlb     = 1'b1;
        dp_ea      = 1'b0;
        dp_eu      = 1'b0;
        dp_sub     = 1'b0;
        dp_bus_sel = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        unique case (state)
            S_SETUP: begin
                dp_data = data_q;
            end
            S_LDB: begin
                dp_data = data_q;
                dp_nlb  = 1'b0;
            end
            S_ALU: begin
                dp_eu  = 1'b1;
                dp_nla = 1'b0;
                dp_sub = (op_q == OP_SUB);
            end
            S_LDA: begin
                dp_data = data_q;
                dp_nla  = 1'b0;
            end
`ifdef ACC_SEQ_OUT_CMD_EN
            S_OUT: begin
                dp_ea      = 1'b1;
                dp_bus_sel = 1'b1;
            end
`endif
            S_DONE: begin
                done = ~bad_q;
                err  = bad_q;
            end
            default: begin
            end
        endcase
    end

    // The datapath registers its flags on the ALU edge, so they are
    // stable here one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cf_q <= 1'b0;
            zf_q <= 1'b0;
        end else if (state == S_FLAG) begin
            cf_q <= dp_cf;
            zf_q <= dp_zf;
        end
    end

    assign busy = (state != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: scoreboard bench for acc_sequencer with a
// behavioural accumulator datapath driven by the DUT strobes.
module tb_acc_sequencer;

    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [7:0] dp_data;
    logic       dp_nla, dp_nlb, dp_ea, dp_eu, dp_sub, dp_bus_sel;
    logic       dp_cf, dp_zf;
    logic       done, err, cf_q, zf_q, busy;

    always #5 clk = ~clk;

    acc_sequencer #(.DATA_W(8), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .dp_data(dp_data), .dp_nla(dp_nla), .dp_nlb(dp_nlb),
        .dp_ea(dp_ea), .dp_eu(dp_eu), .dp_sub(dp_sub),
        .dp_bus_sel(dp_bus_sel), .dp_cf(dp_cf), .dp_zf(dp_zf),
        .done(done), .err(err), .cf_q(cf_q), .zf_q(zf_q),
        .busy(busy)
    );

    // ---------------- datapath model ----------------
    logic [7:0] dpa = 8'd0;
    logic [7:0] dpb = 8'd0;
    logic [7:0] ibuf = 8'd0;
    logic       dcf = 1'b0;
    logic       dzf = 1'b0;
    logic [8:0] alu;
    logic [7:0] bus;

    always_comb begin
        if (dp_sub) alu = {1'b0, dpa} + {1'b0, ~dpb} + 9'd1;
        else        alu = {1'b0, dpa} + {1'b0, dpb};
        if (dp_eu)      bus = alu[7:0];
        else if (dp_ea) bus = dpa;
        else            bus = ibuf;
    end

    always @(posedge clk) begin
        ibuf <= dp_data;
        if (!dp_nlb) dpb <= bus;
        if (!dp_nla) dpa <= bus;
        if (dp_eu) begin
            dcf <= alu[8];
            dzf <= (alu[7:0] == 8'd0);
        end
    end

    assign dp_cf = dcf;
    assign dp_zf = dzf;

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] d;
        bit         bad;
        logic [7:0] a;
        bit         cf;
        bit         zf;
        int         due;
    } exp_t;

    exp_t sb[$];

    int         cyc = 0;
    int         pred_last = -100;
    logic [7:0] m_a = 8'd0;
    bit         m_cf = 1'b0;
    bit         m_zf = 1'b0;
    bit         saw_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_accept(input logic [2:0] op,
                                input logic [7:0] d);
        exp_t e;
        int   lat;
        int   s;
        e.op  = op;
        e.d   = d;
        e.bad = (op == 3'd6) || (op == 3'd7);
`ifndef ACC_SEQ_OUT_CMD_EN
        if (op == 3'd4) e.bad = 1'b1;
`endif
        if (!e.bad) begin
            case (op)
                3'd1: m_a = d;
                3'd2: begin
                    s = int'(m_a) + int'(d);
                    m_cf = (s > 255);
                    m_a = m_a + d;
                    m_zf = (m_a == 8'd0);
                end
                3'd3: begin
                    m_cf = (m_a >= d);
                    m_a = m_a - d;
                    m_zf = (m_a == 8'd0);
                end
                3'd5: m_a = 8'd0;
                default: ;
            endcase
        end
        if (e.bad || op == 3'd0)           lat = 2;
        else if (op == 3'd2 || op == 3'd3) lat = 5;
        else                               lat = 3;
        e.a  = m_a;
        e.cf = m_cf;
        e.zf = m_zf;
        e.due = ((cyc + 1 > pred_last + 1) ? cyc + 1 : pred_last + 1) + lat;
        pred_last = e.due;
        sb.push_back(e);
    endtask

    // Call just after a rising edge; leaves cmd_valid low after the
    // accepting edge unless the next call re-asserts it at once.
    task automatic push(input logic [2:0] op, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                model_accept(op, d);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
        cmd_valid = 1'b0;
        check("push_accept", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle", ok, 1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int         nla_cnt, nlb_cnt, eu_cnt, ea_cnt, nonsafe;
    logic [7:0] nlb_data, out_bus;
    logic       sub_seen, out_sel;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            nla_cnt = 0; nlb_cnt = 0; eu_cnt = 0; ea_cnt = 0;
            nonsafe = 0;
        end else begin
            if (!cmd_ready) saw_full = 1'b1;
            check("ea_eu_excl", dp_ea & dp_eu, 0);
            if (dp_ea || dp_eu) check("data_zero_on_drive", dp_data, 0);
`ifndef ACC_SEQ_OUT_CMD_EN
            check("bus_sel_tied", dp_bus_sel, 0);
`endif
            if (!dp_nla) nla_cnt++;
            if (!dp_nlb) begin
                nlb_cnt++;
                nlb_data = dp_data;
            end
            if (dp_eu) begin
                eu_cnt++;
                sub_seen = dp_sub;
            end
            if (dp_ea) begin
                ea_cnt++;
                out_bus = bus;
                out_sel = dp_bus_sel;
            end
            if (!dp_nla || !dp_nlb || dp_ea || dp_eu || dp_sub || dp_bus_sel)
                nonsafe++;
            if (done || err) begin
                check("done_err_excl", done & err, 0);
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("err_kind", err, e.bad);
                    check("latency", cyc, e.due);
                    check("acc_a", dpa, e.a);
                    check("cf_q", cf_q, e.cf);
                    check("zf_q", zf_q, e.zf);
                    if (e.bad || e.op == 3'd0) begin
                        check("safe_ctrl", nonsafe, 0);
                    end else if (e.op == 3'd2 || e.op == 3'd3) begin
                        check("nlb_once", nlb_cnt, 1);
                        check("nlb_data", nlb_data, e.d);
                        check("alu_once", eu_cnt, 1);
                        check("nla_once", nla_cnt, 1);
                        check("sub_strobe", sub_seen, e.op == 3'd3);
                    end else if (e.op == 3'd4) begin
                        check("out_ea", ea_cnt, 1);
                        check("out_sel", out_sel, 1);
                        check("out_bus", out_bus, e.a);
                    end else begin
                        check("lda_nla", nla_cnt, 1);
                        check("lda_nlb", nlb_cnt, 0);
                    end
                end
                nla_cnt = 0; nlb_cnt = 0; eu_cnt = 0; ea_cnt = 0;
                nonsafe = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, {done, err}, 0);
        check({tag, "_flags"}, {cf_q, zf_q}, 0);
        check({tag, "_ctrl"},
              {dp_nla, dp_nlb, dp_ea, dp_eu, dp_sub, dp_bus_sel}, 6'b110000);
        check({tag, "_data"}, dp_data, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst0");
        @(posedge clk);
        #1;

        push(3'd1, 8'h05);
        push(3'd2, 8'h03);
        push(3'd4, 8'h00);
        wait_idle();
        check("sum_a", dpa, 8'h08);

        push(3'd1, 8'h10);
        push(3'd3, 8'h10);
        wait_idle();
        check("sub_a", dpa, 8'h00);

        push(3'd1, 8'hFF);
        push(3'd2, 8'h01);
        wait_idle();
        check("wrap_a", dpa, 8'h00);

        push(3'd1, 8'h3C);
        push(3'd5, 8'h77);
        wait_idle();

        saw_full = 1'b0;
        push(3'd1, 8'h01);
        push(3'd2, 8'h02);
        push(3'd2, 8'h03);
        push(3'd3, 8'h01);
        push(3'd2, 8'h04);
        push(3'd0, 8'h00);
        wait_idle();
        check("fifo_full_seen", saw_full, 1);
        check("fill_a", dpa, 8'h09);

        push(3'd7, 8'hAA);
        push(3'd0, 8'h00);
        push(3'd6, 8'h55);
        push(3'd4, 8'h00);
        wait_idle();

        push(3'd1, 8'h22);
        push(3'd2, 8'h01);
        push(3'd0, 8'h00);
        push(3'd0, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dp_eu) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach_alu", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        sb.delete();
        pred_last = -100;
        m_a  = 8'h23;
        m_cf = 1'b0;
        m_zf = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("a_hold", dpa, 8'h23);
            check("no_done", {done, err}, 0);
            check("fifo_empty", busy, 0);
        end
        @(posedge clk);
        #1;

        push(3'd2, 8'h10);
        push(3'd1, 8'h42);
        wait_idle();
        check("final_a", dpa, 8'h42);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
